// File: rtl/trax_pkg.sv
// Shared Trax tile definitions: tile codes, sides, edge colours, result codes,
// and the move_placer controller states.
package trax_pkg;

    localparam logic [3:0] TILE_EMPTY  = 4'd0;
    localparam logic [3:0] TILE_RED_NS = 4'd1;
    localparam logic [3:0] TILE_RED_EW = 4'd2;
    localparam logic [3:0] TILE_RED_NE = 4'd3;
    localparam logic [3:0] TILE_RED_ES = 4'd4;
    localparam logic [3:0] TILE_RED_SW = 4'd5;
    localparam logic [3:0] TILE_RED_WN = 4'd6;
    localparam logic [3:0] TILE_MAX    = 4'd6;

    // N = y-1, S = y+1, W = x-1, E = x+1
    typedef enum logic [1:0] {SIDE_N, SIDE_S, SIDE_W, SIDE_E} side_e;

    localparam logic [1:0] RES_OK      = 2'd0;
    localparam logic [1:0] RES_ILLEGAL = 2'd1;
    localparam logic [1:0] RES_EDGE    = 2'd2;
    localparam logic [1:0] RES_FM_ERR  = 2'd3;

    // Order in which the placer reads the five cells around a move
    localparam logic [2:0] CELL_C = 3'd0;
    localparam logic [2:0] CELL_N = 3'd1;
    localparam logic [2:0] CELL_S = 3'd2;
    localparam logic [2:0] CELL_W = 3'd3;
    localparam logic [2:0] CELL_E = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE, ST_PRECHK, ST_RD_ADDR, ST_RD_CAP, ST_CHECK,
        ST_WRITE, ST_FM_START, ST_FM_WAIT, ST_DONE
    } mp_state_e;

    // Codes 7..15 are not tiles; on the board they read as empty
    function automatic logic tile_valid(input logic [3:0] tile);
        return (tile != TILE_EMPTY) && (tile <= TILE_MAX);
    endfunction

    // True when the given side of the tile carries a red line; all other edges are white
    function automatic logic edge_red(input logic [3:0] tile, input side_e side);
        logic red;
        red = 1'b0;
        case (tile)
            TILE_RED_NS: red = (side == SIDE_N) || (side == SIDE_S);
            TILE_RED_EW: red = (side == SIDE_E) || (side == SIDE_W);
            TILE_RED_NE: red = (side == SIDE_N) || (side == SIDE_E);
            TILE_RED_ES: red = (side == SIDE_E) || (side == SIDE_S);
            TILE_RED_SW: red = (side == SIDE_S) || (side == SIDE_W);
            TILE_RED_WN: red = (side == SIDE_W) || (side == SIDE_N);
            default:     red = 1'b0;
        endcase
        return red;
    endfunction

endpackage

// File: rtl/move_placer_if.sv
// Move request, tile SRAM, force_move hand-off and result signals of move_placer.
interface move_placer_if #(
    parameter int X_WIDTH = 10
) ();
    localparam int ADDR_W = 2 * (X_WIDTH + 1);

    logic              move_valid;
    logic              move_ready;
    logic [X_WIDTH:0]  move_x;
    logic [X_WIDTH:0]  move_y;
    logic [3:0]        move_tile;
    logic              first_move;

    logic              sram_ready;
    logic [3:0]        sram_data_in;
    logic [ADDR_W-1:0] sram_addr;
    logic [3:0]        sram_data_out;
    logic              sram_write_en;

    logic              fm_start;
    logic [X_WIDTH:0]  fm_last_x;
    logic [X_WIDTH:0]  fm_last_y;
    logic              fm_active;
    logic              fm_end;
    logic              fm_error;

    logic              res_valid;
    logic [1:0]        res_code;

    // Placer side: SRAM master, force_move launcher, result source
    modport master (
        input  move_valid, move_x, move_y, move_tile, first_move,
        input  sram_ready, sram_data_in, fm_end, fm_error,
        output move_ready, sram_addr, sram_data_out, sram_write_en,
        output fm_start, fm_last_x, fm_last_y, fm_active, res_valid, res_code
    );

    // Environment side: move source, SRAM, force_move and result sink
    modport slave (
        output move_valid, move_x, move_y, move_tile, first_move,
        output sram_ready, sram_data_in, fm_end, fm_error,
        input  move_ready, sram_addr, sram_data_out, sram_write_en,
        input  fm_start, fm_last_x, fm_last_y, fm_active, res_valid, res_code
    );
endinterface

// File: rtl/move_placer_edge_checker.sv
// Compares a new tile against its four neighbours: is any neighbour occupied,
// and does any occupied neighbour present a differently coloured facing edge.
module edge_checker
    import trax_pkg::*;
(
    input  logic [3:0] tile,
    input  logic [3:0] n_cell,
    input  logic [3:0] s_cell,
    input  logic [3:0] w_cell,
    input  logic [3:0] e_cell,
    output logic       adjacent,
    output logic       mismatch
);
    logic n_occ, s_occ, w_occ, e_occ;

    // Neighbour occupancy and facing-edge colour comparison
    always_comb begin
        n_occ    = tile_valid(n_cell);
        s_occ    = tile_valid(s_cell);
        w_occ    = tile_valid(w_cell);
        e_occ    = tile_valid(e_cell);
        adjacent = n_occ | s_occ | w_occ | e_occ;
        mismatch = (n_occ && (edge_red(n_cell, SIDE_S) != edge_red(tile, SIDE_N)))
                || (s_occ && (edge_red(s_cell, SIDE_N) != edge_red(tile, SIDE_S)))
                || (w_occ && (edge_red(w_cell, SIDE_E) != edge_red(tile, SIDE_W)))
                || (e_occ && (edge_red(e_cell, SIDE_W) != edge_red(tile, SIDE_E)));
    end
endmodule

// File: rtl/move_placer.sv
// Move placer: accepts a move, validates it against the tile SRAM, writes the
// tile, hands the cell to force_move and reports one result code per move.
//
// state       | meaning
// IDLE        | ready for a move
// PRECHK      | reject bad tile codes and border coordinates
// RD_ADDR     | present read address of cell idx_q, wait for sram_ready
// RD_CAP      | capture read data for cell idx_q (C, N, S, W, E)
// CHECK       | occupancy, adjacency and edge-colour decision
// WRITE       | write tile into the SRAM once sram_ready
// FM_START    | pulse fm_start, force_move owns the SRAM
// FM_WAIT     | wait for force_move end/error
// DONE        | pulse res_valid with res_code
module move_placer #(
    parameter int X_WIDTH = 10
) (
    input logic          clk,
    input logic          reset,
    move_placer_if.master bus
);
    import trax_pkg::*;

    localparam logic [X_WIDTH:0] COORD_ONE = (X_WIDTH + 1)'(1);

    mp_state_e        state_q, state_d;
    logic [X_WIDTH:0] x_q, x_d, y_q, y_d;
    logic [3:0]       tile_q, tile_d;
    logic             first_q, first_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       cells_q [5];
    logic [3:0]       cells_d [5];
    logic [1:0]       code_q, code_d;
    logic [2*(X_WIDTH+1)-1:0] rd_addr;
    logic             adjacent, mismatch;

    edge_checker u_edge_checker (
        .tile     (tile_q),
        .n_cell   (cells_q[CELL_N]),
        .s_cell   (cells_q[CELL_S]),
        .w_cell   (cells_q[CELL_W]),
        .e_cell   (cells_q[CELL_E]),
        .adjacent (adjacent),
        .mismatch (mismatch)
    );

    // Address of the cell currently being read; PRECHK keeps x/y off the border so no wrap
    always_comb begin
        rd_addr = {y_q, x_q};
        case (idx_q)
            CELL_N:  rd_addr = {y_q - COORD_ONE, x_q};
            CELL_S:  rd_addr = {y_q + COORD_ONE, x_q};
            CELL_W:  rd_addr = {y_q, x_q - COORD_ONE};
            CELL_E:  rd_addr = {y_q, x_q + COORD_ONE};
            default: rd_addr = {y_q, x_q};
        endcase
    end

    assign bus.fm_last_x = x_q;
    assign bus.fm_last_y = y_q;

    // Next-state and output decode
    always_comb begin
        state_d           = state_q;
        x_d               = x_q;
        y_d               = y_q;
        tile_d            = tile_q;
        first_d           = first_q;
        idx_d             = idx_q;
        cells_d           = cells_q;
        code_d            = code_q;
        bus.move_ready    = 1'b0;
        bus.sram_addr     = '0;
        bus.sram_data_out = '0;
        bus.sram_write_en = 1'b0;
        bus.fm_start      = 1'b0;
        bus.fm_active     = 1'b0;
        bus.res_valid     = 1'b0;
        bus.res_code      = RES_OK;
        case (state_q)
            ST_IDLE: begin
                bus.move_ready = 1'b1;
                if (bus.move_valid) begin
                    x_d     = bus.move_x;
                    y_d     = bus.move_y;
                    tile_d  = bus.move_tile;
                    first_d = bus.first_move;
                    idx_d   = CELL_C;
                    code_d  = RES_OK;
                    state_d = ST_PRECHK;
                end
            end
            ST_PRECHK: begin
                if (!tile_valid(tile_q) || x_q == '0 || x_q == '1 || y_q == '0 || y_q == '1) begin
                    code_d  = RES_ILLEGAL;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                bus.sram_addr = rd_addr;
                if (bus.sram_ready) state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                bus.sram_addr  = rd_addr;
                cells_d[idx_q] = bus.sram_data_in;
                if (idx_q == CELL_E) begin
                    state_d = ST_CHECK;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_RD_ADDR;
                end
            end
            ST_CHECK: begin
                state_d = ST_DONE;
                if (cells_q[CELL_C] != TILE_EMPTY)  code_d = RES_ILLEGAL;
                else if (!adjacent && !first_q)     code_d = RES_ILLEGAL;
                else if (mismatch)                  code_d = RES_EDGE;
                else                                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                bus.sram_addr     = {y_q, x_q};
                bus.sram_data_out = tile_q;
                bus.sram_write_en = bus.sram_ready;
                if (bus.sram_ready) state_d = ST_FM_START;
            end
            ST_FM_START: begin
                bus.fm_active = 1'b1;
                bus.fm_start  = 1'b1;
                state_d       = ST_FM_WAIT;
            end
            ST_FM_WAIT: begin
                bus.fm_active = 1'b1;
                if (bus.fm_error) begin
                    code_d  = RES_FM_ERR;
                    state_d = ST_DONE;
                end else if (bus.fm_end) begin
                    code_d  = RES_OK;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.res_valid = 1'b1;
                bus.res_code  = code_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured-move registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            tile_q  <= TILE_EMPTY;
            first_q <= 1'b0;
            idx_q   <= CELL_C;
            cells_q <= '{default: TILE_EMPTY};
            code_q  <= RES_OK;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tile_q  <= tile_d;
            first_q <= first_d;
            idx_q   <= idx_d;
            cells_q <= cells_d;
            code_q  <= code_d;
        end
    end
endmodule

// File: tb/tb_move_placer.sv
// Bench for move_placer on a 16x16 board (X_WIDTH=3): directed table, two
// multi-cycle sequences, then random moves against a board-level reference.
module tb_move_placer;
    localparam int XW   = 3;
    localparam int CMAX = 15;

    typedef struct {
        int pre_addr; int pre_val;
        int x; int y; int tile; int first; int fm_kind;
        int exp_code; int exp_lat; int exp_wr;
    } vec_t;

    logic clk;
    logic reset;
    logic [3:0] mem [256];
    int ref_mem [256];
    int n_checks, n_fail;
    int wr_count, wr_addr, wr_data;
    vec_t vecs[$];

    move_placer_if #(.X_WIDTH(XW)) bus ();
    move_placer #(.X_WIDTH(XW)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: SRAM model writes on the edge, read data appears the cycle after the address
    task automatic tick();
        logic [7:0] a;
        logic [3:0] d;
        logic we, rdy;
        @(posedge clk);
        a = bus.sram_addr; d = bus.sram_data_out;
        we = bus.sram_write_en; rdy = bus.sram_ready;
        #1;
        if (we && rdy) begin
            mem[a] = d; wr_count++; wr_addr = int'(a); wr_data = int'(d);
        end
        bus.sram_data_in = mem[a];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin mem[i] = 4'd0; ref_mem[i] = 0; end
    endtask

    // Red sides of each tile: dir 0=N(y-1) 1=S(y+1) 2=W(x-1) 3=E(x+1)
    function automatic bit red(input int t, input int dir);
        case (t)
            1: return dir == 0 || dir == 1;
            2: return dir == 2 || dir == 3;
            3: return dir == 0 || dir == 3;
            4: return dir == 3 || dir == 1;
            5: return dir == 1 || dir == 2;
            6: return dir == 2 || dir == 0;
            default: return 0;
        endcase
    endfunction

    // Board rules: 0 legal (tile gets written), 1 illegal position, 2 edge mismatch
    function automatic int ref_check(input int x, input int y, input int t, input int first);
        int nx, ny, nb;
        bit adj, mm;
        if (t < 1 || t > 6 || x == 0 || x == CMAX || y == 0 || y == CMAX) return 1;
        if (ref_mem[y*16 + x] != 0) return 1;
        adj = 0; mm = 0;
        for (int d = 0; d < 4; d++) begin
            nx = x + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
            ny = y + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
            nb = ref_mem[ny*16 + nx];
            if (nb >= 1 && nb <= 6) begin
                adj = 1;
                if (red(nb, d ^ 1) != red(t, d)) mm = 1;
            end
        end
        if (!adj && first == 0) return 1;
        if (mm) return 2;
        return 0;
    endfunction

    // Drive one move to completion; fm_kind 0 end, 1 error, 2 both
    task automatic run_move(input int x, input int y, input int tile, input int first,
                            input int fm_kind, input int fm_delay, input int rdy_pct,
                            input int stall_addr, input int stall_n,
                            output int code, output int lat, output int writes,
                            output int fm_starts, output int stall_seen);
        int fs_at, wr0, stalls;
        bit done;
        wr0 = wr_count; code = -1; lat = -1; fm_starts = 0; fs_at = -1;
        stalls = stall_n; stall_seen = 0; done = 0;
        check("move_ready_idle", int'(bus.move_ready), 1);
        bus.move_valid = 1'b1;
        bus.move_x = (XW+1)'(x); bus.move_y = (XW+1)'(y);
        bus.move_tile = 4'(tile); bus.first_move = (first != 0);
        tick();
        bus.move_valid = 1'b0;
        for (int cyc = 1; cyc < 300 && !done; cyc++) begin
            bus.fm_end = 1'b0; bus.fm_error = 1'b0;
            if (bus.res_valid) begin
                code = int'(bus.res_code); lat = cyc; done = 1;
            end else begin
                if (bus.fm_start) begin
                    fm_starts++; fs_at = cyc;
                    check("fm_last_x", int'(bus.fm_last_x), x);
                    check("fm_last_y", int'(bus.fm_last_y), y);
                end
                if (fs_at >= 0 && cyc == fs_at + fm_delay) begin
                    bus.fm_end = (fm_kind != 1); bus.fm_error = (fm_kind != 0);
                end
                if (stalls > 0 && int'(bus.sram_addr) == stall_addr && !bus.fm_active) begin
                    bus.sram_ready = 1'b0; stalls--; stall_seen++;
                end else begin
                    bus.sram_ready = (int'($urandom_range(99)) < rdy_pct);
                end
                tick();
            end
        end
        if (!done) check("res_valid_timeout", 0, 1);
        bus.sram_ready = 1'b1;
        tick();
        check("res_valid_one_cycle", int'(bus.res_valid), 0);
        writes = wr_count - wr0;
    endtask

    initial begin
        int code, lat, wr, fms, stl, found, rv, wr_before, exp, kind, placed, first, diffs;
        int x, y, t;
        n_checks = 0; n_fail = 0; wr_count = 0; wr_addr = -1; wr_data = -1;
        bus.move_valid = 0; bus.move_x = '0; bus.move_y = '0; bus.move_tile = '0;
        bus.first_move = 0; bus.sram_ready = 1; bus.sram_data_in = '0;
        bus.fm_end = 0; bus.fm_error = 0;
        clear_mem();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_move_ready", int'(bus.move_ready), 1);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_res_code", int'(bus.res_code), 0);
        check("rst_fm_active", int'(bus.fm_active), 0);
        check("rst_fm_start", int'(bus.fm_start), 0);
        check("rst_write_en", int'(bus.sram_write_en), 0);
        check("rst_sram_addr", int'(bus.sram_addr), 0);
        check("rst_fm_last_x", int'(bus.fm_last_x), 0);

        // pre_addr, pre_val, x, y, tile, first, fm_kind, exp_code, exp_lat, exp_wr
        vecs.push_back('{-1,  0,  5,  5, 1, 1, 0, 0, 16, 1});
        vecs.push_back('{85,  1,  5,  5, 2, 0, 0, 1, 13, 0});
        vecs.push_back('{69,  1,  5,  5, 2, 0, 0, 2, 13, 0});
        vecs.push_back('{69,  1,  5,  5, 1, 0, 0, 0, 16, 1});
        vecs.push_back('{-1,  0,  9,  9, 1, 0, 0, 1, 13, 0});
        vecs.push_back('{-1,  0,  0,  5, 1, 1, 0, 1,  2, 0});
        vecs.push_back('{-1,  0,  5,  5, 7, 1, 0, 1,  2, 0});
        vecs.push_back('{-1,  0,  5, 15, 1, 1, 0, 1,  2, 0});
        vecs.push_back('{-1,  0, 15,  5, 1, 1, 0, 1,  2, 0});
        vecs.push_back('{-1,  0,  5,  5, 0, 1, 0, 1,  2, 0});
        vecs.push_back('{86,  2,  5,  5, 3, 0, 0, 0, 16, 1});
        vecs.push_back('{101, 1,  5,  5, 3, 0, 0, 2, 13, 0});
        vecs.push_back('{84,  9,  5,  5, 1, 0, 0, 1, 13, 0});
        vecs.push_back('{-1,  0,  5,  5, 4, 1, 1, 3, 16, 1});
        vecs.push_back('{-1,  0,  5,  5, 4, 1, 2, 3, 16, 1});
        vecs.push_back('{84,  5,  5,  5, 1, 0, 0, 0, 16, 1});
        vecs.push_back('{-1,  0,  1,  1, 2, 1, 0, 0, 16, 1});
        vecs.push_back('{-1,  0, 14, 14, 5, 1, 0, 0, 16, 1});

        foreach (vecs[i]) begin
            clear_mem();
            if (vecs[i].pre_addr >= 0) begin
                mem[vecs[i].pre_addr] = 4'(vecs[i].pre_val);
                ref_mem[vecs[i].pre_addr] = vecs[i].pre_val;
            end
            run_move(vecs[i].x, vecs[i].y, vecs[i].tile, vecs[i].first, vecs[i].fm_kind,
                     1, 100, -1, 0, code, lat, wr, fms, stl);
            check($sformatf("vec%0d_code", i), code, vecs[i].exp_code);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_writes", i), wr, vecs[i].exp_wr);
            check($sformatf("vec%0d_fm_starts", i), fms, vecs[i].exp_wr);
            if (vecs[i].exp_wr == 1) begin
                check($sformatf("vec%0d_wr_addr", i), wr_addr, vecs[i].y*16 + vecs[i].x);
                check($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].tile);
            end
        end

        // Stall the west-neighbour read for 5 cycles, then force_move reports an error
        clear_mem();
        run_move(5, 5, 1, 1, 1, 2, 100, 5*16 + 4, 5, code, lat, wr, fms, stl);
        check("stall_cycles_addr_held", stl, 5);
        check("stall_code", code, 3);
        check("stall_latency", lat, 22);
        check("stall_writes", wr, 1);
        check("stall_wr_data", int'(mem[85]), 1);

        // Reset while waiting on force_move
        clear_mem();
        bus.move_valid = 1'b1; bus.move_x = 4'd5; bus.move_y = 4'd5;
        bus.move_tile = 4'd1; bus.first_move = 1'b1;
        tick();
        bus.move_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            if (bus.fm_active && !bus.fm_start) found = 1;
            else tick();
        end
        check("reach_fm_wait", found, 1);
        wr_before = wr_count;
        reset = 1'b1;
        tick();
        check("rstwait_fm_active", int'(bus.fm_active), 0);
        check("rstwait_move_ready", int'(bus.move_ready), 1);
        check("rstwait_res_valid", int'(bus.res_valid), 0);
        reset = 1'b0;
        rv = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.res_valid) rv++;
        end
        check("rstwait_no_result", rv, 0);
        check("rstwait_no_write", wr_count - wr_before, 0);
        check("rstwait_no_rollback", int'(mem[85]), 1);
        ref_mem[85] = 1;
        run_move(5, 5, 2, 0, 0, 1, 100, -1, 0, code, lat, wr, fms, stl);
        check("after_rst_code", code, 1);

        // Random moves against the board-level reference
        clear_mem();
        placed = 0;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(7) == 0) begin
                x = int'($urandom_range(CMAX)); y = int'($urandom_range(CMAX));
            end else begin
                x = int'($urandom_range(4, 11)); y = int'($urandom_range(4, 11));
            end
            t = int'($urandom_range(8));
            first = (placed == 0) ? 1 : (($urandom_range(9) == 0) ? 1 : 0);
            kind = ($urandom_range(3) == 0) ? int'($urandom_range(1, 2)) : 0;
            exp = ref_check(x, y, t, first);
            run_move(x, y, t, first, kind, int'($urandom_range(1, 4)), 70, -1, 0,
                     code, lat, wr, fms, stl);
            if (exp == 0) begin
                ref_mem[y*16 + x] = t;
                placed++;
                exp = (kind == 0) ? 0 : 3;
                check($sformatf("rnd%0d_wr_addr", n), wr_addr, y*16 + x);
            end
            check($sformatf("rnd%0d_code", n), code, exp);
            check($sformatf("rnd%0d_writes", n), wr, (exp == 0 || exp == 3) ? 1 : 0);
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) if (int'(mem[i]) != ref_mem[i]) diffs++;
        check("final_board_diffs", diffs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
